axil_crossbar_port_arb: RTL and testbench

Per-master-port arbiter for the AXI4-lite crossbar. It shares one master interface between S_COUNT slave-side address decoders. It grants a single requester, forwards its address handshake, and holds the grant until that transaction's response completes. One instance sits on each AW path and each AR path of every master port, downstream of the address decode/admission stage.

---
 rtl/axil_crossbar_port_arb.sv | 200 ++++++++++++++++++++
 tb/tb_axil_crossbar_port_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_crossbar_port_arb.sv
// axil_crossbar_port_arb
//
// Per-master-port arbiter for the AXI4-lite crossbar. Shares one master address channel
// (AW or AR) between S_COUNT requesters. It grants one requester, drives its address valid,
// and holds the grant until the transaction's response handshake (m_done) completes.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   s_req          per-requester address valid
//   s_ack          one-cycle pulse: granted requester's address accepted
//   grant          one-hot current grant
//   grant_encoded  binary index of grant
//   grant_valid    grant active
//   m_avalid       address valid to master port
//   m_aready       address ready from master port
//   m_done         response handshake of the granted transaction
//   timeout_err    one-cycle pulse: response watchdog released the grant
//
// Build option: define AXIL_PORT_ARB_TIMEOUT_EN to add a response watchdog of
// TIMEOUT_CYCLES cycles. Without it timeout_err is tied low and RESP waits forever.
// All outputs are driven straight from flops.

module axil_crossbar_port_arb #(
  parameter int unsigned S_COUNT         = 4,
  parameter int unsigned ARB_ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned CL_S_COUNT     = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_COUNT-1:0]    s_req,
  output logic [S_COUNT-1:0]    s_ack,
  output logic [S_COUNT-1:0]    grant,
  output logic [CL_S_COUNT-1:0] grant_encoded,
  output logic                  grant_valid,
  output logic                  m_avalid,
  input  logic                  m_aready,
  input  logic                  m_done,
  output logic                  timeout_err
);

  if (S_COUNT < 1 || S_COUNT > 32) begin : g_bad_s_count
    $error("S_COUNT must be in 1..32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e                  state_q, state_d;
  logic [S_COUNT-1:0]      grant_q, grant_d;
  logic [S_COUNT-1:0]      s_ack_q, s_ack_d;
  logic [CL_S_COUNT-1:0]   grant_enc_q, grant_enc_d;
  logic [CL_S_COUNT-1:0]   last_grant_q, last_grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    m_avalid_q, m_avalid_d;

`ifdef AXIL_PORT_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  // Arbitration. In RESP the search starts after the current grant, which becomes
  // last_grant on the same m_done cycle, so the re-arbitration has no bubble.
  logic [CL_S_COUNT-1:0] arb_last;
  logic [CL_S_COUNT-1:0] arb_idx;
  logic                  arb_found;
  logic [S_COUNT-1:0]    req_shift;
  int unsigned           cand;

  always_comb begin
    arb_last  = (state_q == StResp) ? grant_enc_q : last_grant_q;
    arb_found = 1'b0;
    arb_idx   = '0;
    req_shift = '0;
    cand      = 0;
    for (int unsigned k = 0; k < S_COUNT; k++) begin
      if (ARB_ROUND_ROBIN != 0) begin
        cand = (32'(arb_last) + k + 1) % S_COUNT;
      end else begin
        cand = k;
      end
      req_shift = s_req >> cand;
      if (!arb_found && req_shift[0]) begin
        arb_found = 1'b1;
        arb_idx   = CL_S_COUNT'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_enc_d   = grant_enc_q;
    grant_valid_d = grant_valid_q;
    m_avalid_d    = m_avalid_q;
    last_grant_d  = last_grant_q;
    s_ack_d       = '0;
`ifdef AXIL_PORT_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          grant_enc_d      = arb_idx;
          grant_valid_d    = 1'b1;
          m_avalid_d       = 1'b1;
          state_d          = StAddr;
        end
      end
      // s_req and m_done are ignored here; the grant is held until the address is taken.
      StAddr: begin
        if (m_aready) begin
          m_avalid_d = 1'b0;
          s_ack_d    = grant_q;
          state_d    = StResp;
`ifdef AXIL_PORT_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      StResp: begin
        if (m_done) begin
          last_grant_d = grant_enc_q;
          if (arb_found) begin
            grant_d          = '0;
            grant_d[arb_idx] = 1'b1;
            grant_enc_d      = arb_idx;
            m_avalid_d       = 1'b1;
            state_d          = StAddr;
          end else begin
            grant_d       = '0;
            grant_enc_d   = '0;
            grant_valid_d = 1'b0;
            state_d       = StIdle;
          end
        end
`ifdef AXIL_PORT_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Treat the abandoned transaction as served so the stuck requester drops priority.
          last_grant_d  = grant_enc_q;
          timeout_err_d = 1'b1;
          grant_d       = '0;
          grant_enc_d   = '0;
          grant_valid_d = 1'b0;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_enc_q   <= '0;
      grant_valid_q <= 1'b0;
      m_avalid_q    <= 1'b0;
      s_ack_q       <= '0;
      last_grant_q  <= CL_S_COUNT'(S_COUNT - 1);
`ifdef AXIL_PORT_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_enc_q   <= grant_enc_d;
      grant_valid_q <= grant_valid_d;
      m_avalid_q    <= m_avalid_d;
      s_ack_q       <= s_ack_d;
      last_grant_q  <= last_grant_d;
`ifdef AXIL_PORT_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign grant_encoded = grant_enc_q;
  assign grant_valid   = grant_valid_q;
  assign m_avalid      = m_avalid_q;
  assign s_ack         = s_ack_q;
`ifdef AXIL_PORT_ARB_TIMEOUT_EN
  assign timeout_err   = timeout_err_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_axil_crossbar_port_arb.sv
// Directed bench for axil_crossbar_port_arb: a round-robin instance and a fixed-priority
// instance (S_COUNT=4, TIMEOUT_CYCLES=8) share clock and reset.

module tb_axil_crossbar_port_arb;

  logic       clk = 1'b0;
  logic       rst;
  // Round-robin instance
  logic [3:0] s_req, s_ack, grant;
  logic [1:0] grant_encoded;
  logic       grant_valid, m_avalid, m_aready, m_done, timeout_err;
  // Fixed-priority instance
  logic [3:0] s_req_fp, s_ack_fp, grant_fp;
  logic [1:0] grant_encoded_fp;
  logic       grant_valid_fp, m_avalid_fp, m_aready_fp, m_done_fp, timeout_err_fp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axil_crossbar_port_arb #(
    .S_COUNT        (4),
    .ARB_ROUND_ROBIN(1),
    .TIMEOUT_CYCLES (8)
  ) dut_rr (
    .clk          (clk),
    .rst          (rst),
    .s_req        (s_req),
    .s_ack        (s_ack),
    .grant        (grant),
    .grant_encoded(grant_encoded),
    .grant_valid  (grant_valid),
    .m_avalid     (m_avalid),
    .m_aready     (m_aready),
    .m_done       (m_done),
    .timeout_err  (timeout_err)
  );

  axil_crossbar_port_arb #(
    .S_COUNT        (4),
    .ARB_ROUND_ROBIN(0),
    .TIMEOUT_CYCLES (8)
  ) dut_fp (
    .clk          (clk),
    .rst          (rst),
    .s_req        (s_req_fp),
    .s_ack        (s_ack_fp),
    .grant        (grant_fp),
    .grant_encoded(grant_encoded_fp),
    .grant_valid  (grant_valid_fp),
    .m_avalid     (m_avalid_fp),
    .m_aready     (m_aready_fp),
    .m_done       (m_done_fp),
    .timeout_err  (timeout_err_fp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rr_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  oh;

    rst = 1'b1;
    s_req = '0; m_aready = 1'b0; m_done = 1'b0;
    s_req_fp = '0; m_aready_fp = 1'b0; m_done_fp = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", grant_valid, 1'b0);
    check("rst_avalid", m_avalid, 1'b0);
    check("rst_ack", s_ack, 4'b0000);
    check("rst_tmo", timeout_err, 1'b0);

    // Single request from index 2
    s_req = 4'b0100;
    step();
    check("single_grant", grant, 4'b0100);
    check("single_enc", grant_encoded, 2);
    check("single_avalid", m_avalid, 1'b1);
    check("single_valid", grant_valid, 1'b1);
    m_aready = 1'b1;
    step();
    m_aready = 1'b0;
    s_req = '0;
    check("single_ack", s_ack, 4'b0100);
    check("single_avalid_drop", m_avalid, 1'b0);
    step();
    check("single_ack_pulse", s_ack, 4'b0000);
    check("single_hold_resp", grant_valid, 1'b1);
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("single_release", grant_valid, 1'b0);
    check("single_grant_clr", grant, 4'b0000);

    // Round-robin with all requests held, back-to-back transactions
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_req = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      oh = 4'b0001 << rr_order[t];
      check("rr_enc", grant_encoded, rr_order[t]);
      check("rr_grant", grant, oh);
      check("rr_avalid", m_avalid, 1'b1);
      check("rr_valid", grant_valid, 1'b1);
      m_aready = 1'b1;
      step();
      m_aready = 1'b0;
      check("rr_ack", s_ack, oh);
      check("rr_valid_resp", grant_valid, 1'b1);
      if (t == 4) s_req = '0;
      m_done = 1'b1;
      step();
      m_done = 1'b0;
    end
    check("rr_idle", grant_valid, 1'b0);

    // Fixed priority: index 1 always beats index 3
    s_req_fp = 4'b1010;
    step();
    for (int t = 0; t < 3; t++) begin
      check("fp_enc", grant_encoded_fp, 1);
      check("fp_avalid", m_avalid_fp, 1'b1);
      m_aready_fp = 1'b1;
      step();
      m_aready_fp = 1'b0;
      check("fp_ack", s_ack_fp, 4'b0010);
      if (t == 2) s_req_fp = 4'b1000;
      m_done_fp = 1'b1;
      step();
      m_done_fp = 1'b0;
    end
    check("fp_enc3", grant_encoded_fp, 3);
    check("fp_grant3", grant_fp, 4'b1000);
    check("fp_valid3", grant_valid_fp, 1'b1);
    m_aready_fp = 1'b1;
    step();
    m_aready_fp = 1'b0;
    s_req_fp = '0;
    check("fp_ack3", s_ack_fp, 4'b1000);
    m_done_fp = 1'b1;
    step();
    m_done_fp = 1'b0;
    check("fp_idle", grant_valid_fp, 1'b0);

    // Address stall: last_grant is 0, so index 1 wins; changes to s_req and m_done are ignored
    s_req = 4'b0010;
    step();
    check("stall_grant0", grant, 4'b0010);
    s_req = 4'b0001;
    m_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_avalid", m_avalid, 1'b1);
      check("stall_grant", grant, 4'b0010);
      check("stall_enc", grant_encoded, 1);
      check("stall_ack", s_ack, 4'b0000);
    end
    m_done = 1'b0;
    m_aready = 1'b1;
    step();
    m_aready = 1'b0;
    check("stall_ack_end", s_ack, 4'b0010);

    // Reset while in RESP with grant 0010
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_valid", grant_valid, 1'b0);
    check("mid_rst_avalid", m_avalid, 1'b0);
    s_req = 4'b0011;
    step();
    check("post_rst_grant", grant, 4'b0001);
    check("post_rst_enc", grant_encoded, 0);
    m_aready = 1'b1;
    step();
    m_aready = 1'b0;
    s_req = '0;
    check("post_rst_ack", s_ack, 4'b0001);
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("post_rst_idle", grant_valid, 1'b0);

`ifdef AXIL_PORT_ARB_TIMEOUT_EN
    // Watchdog fires 8 cycles after entering RESP
    s_req = 4'b0001;
    step();
    m_aready = 1'b1;
    step();
    m_aready = 1'b0;
    s_req = '0;
    for (int i = 1; i < 8; i++) begin
      step();
      check("tmo_quiet", timeout_err, 1'b0);
      check("tmo_hold", grant_valid, 1'b1);
    end
    step();
    check("tmo_pulse", timeout_err, 1'b1);
    check("tmo_release", grant_valid, 1'b0);
    check("tmo_grant_clr", grant, 4'b0000);
    step();
    check("tmo_pulse_end", timeout_err, 1'b0);

    // m_done on the terminal count wins over the watchdog
    s_req = 4'b0001;
    step();
    m_aready = 1'b1;
    step();
    m_aready = 1'b0;
    s_req = '0;
    for (int i = 1; i < 8; i++) begin
      step();
      check("tmo2_quiet", timeout_err, 1'b0);
    end
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("tmo2_no_err", timeout_err, 1'b0);
    check("tmo2_release", grant_valid, 1'b0);
`else
    // No watchdog: RESP holds indefinitely
    s_req = 4'b0001;
    step();
    m_aready = 1'b1;
    step();
    m_aready = 1'b0;
    s_req = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("notmo_quiet", timeout_err, 1'b0);
      check("notmo_hold", grant_valid, 1'b1);
    end
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("notmo_release", grant_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
